mbinit_reversal_ctrl: RTL
=========================

Name: mbinit_reversal_ctrl

Overview:
Parametrised MBINIT lane-reversal controller.
- Runs the sideband handshake sequence: init_req, clear_error_req, LaneID pattern, result_req, optional reversal, done_req.
- Generalised over lane count and pass threshold. Supports a bounded number of reversal retries.
- Adds a per-handshake response timeout, a terminal error state and pass-count/status outputs.
- Sits between the MBINIT sequencer (start/end), the sideband TX/RX wrappers and the mainband lane-mapping logic.

Parameters:
NUM_LANES, 16, width of the logged per-lane result vector
PASS_THRESHOLD, 8, minimum passing lanes for success (1..NUM_LANES)
MAX_REVERSALS, 1, reversal attempts allowed before error (0 = never reverse)
TIMEOUT_CYCLES, 4096, max cycles waiting for busy-fall or a response; 0 disables the timeout
CNT_W, $clog2(NUM_LANES+1), width of o_pass_count

Ports:
CLK  in  1  clock
rst  in  1  synchronous active-high reset
i_start  in  1  level enable from MBINIT sequencer (REPAIRVAL complete); deassert aborts to IDLE
i_Busy_SideBand  in  1  sideband TX busy
i_falling_edge_busy  in  1  one-cycle pulse: TX finished sending
i_msg_valid  in  1  RX message valid strobe
i_Rx_SbMessage  in  4  RX message code
i_Result_logged  in  NUM_LANES  per-lane pass bits, valid with result_resp
i_LaneID_Pattern_done  in  1  pattern generator finished
i_REVERSAL_done  in  1  lane map swap completed
o_LaneID_Pattern_En  out  2  2'b11 = per-lane LaneID pattern, else 0
o_ApplyReversal_En  out  1  request lane map swap
o_reversal_active  out  1  current lane map is reversed
o_TX_SbMessage  out  4  TX message code
o_ValidOutDatat_Module  out  1  TX request valid
o_Module_end  out  1  sequence passed
o_train_error_req  out  1  sequence failed (timeout or retries exhausted)
o_pass_count  out  CNT_W  popcount of the last latched result
o_try_count  out  $clog2(MAX_REVERSALS+1)  reversals applied so far

Behaviour:
- Reset (rst high at a CLK edge): state IDLE; all outputs 0; counters 0.
- Message codes:
  - init_req 1, init_resp 2
  - clear_error_req 3, clear_error_resp 4
  - result_req 5, result_resp 6
  - done_req 7, done_resp 8
- Outputs are registered from the next state, so they are visible the cycle after the transition decision.
- States:
  - IDLE: i_start && !busy -> SEND(init).
  - WAIT_IDLE(msg): !busy -> SEND(msg).
  - SEND(msg): hold o_ValidOutDatat_Module=1 and o_TX_SbMessage=msg; i_falling_edge_busy -> WAIT_RESP(msg+1).
  - WAIT_RESP(code): advances only on i_msg_valid && i_Rx_SbMessage==code.
    - init_resp -> WAIT_IDLE(clear_error)
    - clear_error_resp -> LANEID
    - result_resp -> CHECK, latching o_pass_count = popcount(i_Result_logged)
    - done_resp -> DONE
    - Valid messages with any other code are ignored.
  - LANEID: o_LaneID_Pattern_En=2'b11; i_LaneID_Pattern_done -> WAIT_IDLE(result).
  - CHECK (one cycle):
    - pass_count >= PASS_THRESHOLD -> WAIT_IDLE(done).
    - else try_count < MAX_REVERSALS -> APPLY.
    - else ERROR.
  - APPLY: o_ApplyReversal_En=1; on i_REVERSAL_done: try_count++, toggle o_reversal_active, -> WAIT_IDLE(clear_error).
  - DONE: o_Module_end=1, held until abort.
  - ERROR: o_train_error_req=1, held until abort.
- Abort: i_start low in any state -> IDLE next cycle; outputs clear.
  - try_count and o_reversal_active are kept through an abort; only rst clears them.
  - o_pass_count is kept until the next result_resp.
- Timeout: counter clears on entry to each SEND/WAIT_RESP state and increments each cycle there.
  - Reaching TIMEOUT_CYCLES-1 without the exit event -> ERROR.
  - The exit event wins if it coincides with timeout.
- Simultaneous events:
  - Abort has priority over everything except rst.
  - A response arriving while in SEND (before busy-fall) is not captured.
- Popcount is purely combinational over NUM_LANES bits; the result is registered on capture.

Test Plan:
1. Pass first try: NUM_LANES=16, result 16'hFFFF -> TX sequence 1,3,5,7; o_pass_count=16; o_Module_end=1; o_try_count=0; o_reversal_active=0.
2. Reverse then pass: first result 16'h00FF (8 lanes), PASS_THRESHOLD=9 -> APPLY, o_try_count=1, o_reversal_active=1, clear_error_req (3) resent; second result 16'hFFFF -> o_Module_end=1.
3. Retries exhausted: MAX_REVERSALS=1, both results 16'h0003 -> exactly one reversal, then o_train_error_req=1 and o_Module_end stays 0.
4. Timeout: TIMEOUT_CYCLES=16, withhold init_resp -> ERROR reached 16 cycles after WAIT_RESP entry. Response arriving on cycle 15 -> no error.
5. Wrong/ignored messages: in WAIT_RESP(2), send code 6 with valid -> state unchanged; code 2 without valid -> unchanged.
6. Abort and reset: drop i_start during LANEID -> LaneID_Pattern_En=0 next cycle, IDLE; reassert -> init_req resent. rst mid-APPLY -> all outputs 0 and try_count=0.

Source files
------------

// File: rtl/mbinit_reversal_ctrl.sv
// MBINIT lane-reversal controller: drives the sideband init / clear-error / result /
// done handshakes, the LaneID pattern phase and bounded lane-reversal retries.
module mbinit_reversal_ctrl #(
   parameter int NUM_LANES      = 16,
   parameter int PASS_THRESHOLD = 8,
   parameter int MAX_REVERSALS  = 1,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int CNT_W          = $clog2(NUM_LANES + 1),
   parameter int TRY_W          = (MAX_REVERSALS > 0) ? $clog2(MAX_REVERSALS + 1) : 1
) (
   input  logic                 CLK,
   input  logic                 rst,
   input  logic                 i_start,
   input  logic                 i_Busy_SideBand,
   input  logic                 i_falling_edge_busy,
   input  logic                 i_msg_valid,
   input  logic [3:0]           i_Rx_SbMessage,
   input  logic [NUM_LANES-1:0] i_Result_logged,
   input  logic                 i_LaneID_Pattern_done,
   input  logic                 i_REVERSAL_done,
   output logic [1:0]           o_LaneID_Pattern_En,
   output logic                 o_ApplyReversal_En,
   output logic                 o_reversal_active,
   output logic [3:0]           o_TX_SbMessage,
   output logic                 o_ValidOutDatat_Module,
   output logic                 o_Module_end,
   output logic                 o_train_error_req,
   output logic [CNT_W-1:0]     o_pass_count,
   output logic [TRY_W-1:0]     o_try_count
);

   localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
   localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);

   localparam logic [3:0] MSG_INIT_REQ  = 4'd1;
   localparam logic [3:0] MSG_INIT_RESP = 4'd2;
   localparam logic [3:0] MSG_CLR_REQ   = 4'd3;
   localparam logic [3:0] MSG_CLR_RESP  = 4'd4;
   localparam logic [3:0] MSG_RES_REQ   = 4'd5;
   localparam logic [3:0] MSG_RES_RESP  = 4'd6;
   localparam logic [3:0] MSG_DONE_REQ  = 4'd7;
   localparam logic [3:0] MSG_DONE_RESP = 4'd8;

   typedef enum logic [3:0] {
      S_IDLE, S_WAIT_IDLE, S_SEND, S_WAIT_RESP, S_LANEID,
      S_CHECK, S_APPLY, S_DONE, S_ERROR
   } state_t;

   function automatic logic [CNT_W-1:0] popcount(input logic [NUM_LANES-1:0] v);
      logic [CNT_W-1:0] s;
      s = '0;
      for (int i = 0; i < NUM_LANES; i++) s = s + CNT_W'(v[i]);
      return s;
   endfunction

   state_t           r_state;
   logic [3:0]       r_msg;
   logic [TMO_W-1:0] r_tmo_cnt;
   logic [1:0]       r_lane_en;
   logic             r_apply_en;
   logic             r_rev_active;
   logic [3:0]       r_tx_msg;
   logic             r_tx_vld;
   logic             r_end;
   logic             r_err;
   logic [CNT_W-1:0] r_pass_count;
   logic [TRY_W-1:0] r_try_count;

   state_t     w_nxt_state;
   logic [3:0] w_nxt_msg;
   logic       w_capture;
   logic       w_try_inc;
   logic       w_tmo;
   logic       w_resp_hit;

   assign w_tmo      = TMO_EN && (r_tmo_cnt == TMO_LAST);
   assign w_resp_hit = i_msg_valid && (i_Rx_SbMessage == r_msg);

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_msg   = r_msg;
      w_capture   = 1'b0;
      w_try_inc   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!i_Busy_SideBand) begin
               w_nxt_state = S_SEND;
               w_nxt_msg   = MSG_INIT_REQ;
            end
         end
         S_WAIT_IDLE: begin
            if (!i_Busy_SideBand) w_nxt_state = S_SEND;
         end
         S_SEND: begin
            if (i_falling_edge_busy) begin
               w_nxt_state = S_WAIT_RESP;
               w_nxt_msg   = r_msg + 4'd1;
            end else if (w_tmo) begin
               w_nxt_state = S_ERROR;
            end
         end
         S_WAIT_RESP: begin
            // the awaited response takes precedence over a coincident timeout
            if (w_resp_hit) begin
               case (r_msg)
                  MSG_INIT_RESP: begin
                     w_nxt_state = S_WAIT_IDLE;
                     w_nxt_msg   = MSG_CLR_REQ;
                  end
                  MSG_CLR_RESP:  w_nxt_state = S_LANEID;
                  MSG_RES_RESP: begin
                     w_nxt_state = S_CHECK;
                     w_capture   = 1'b1;
                  end
                  MSG_DONE_RESP: w_nxt_state = S_DONE;
                  default:       w_nxt_state = S_ERROR;
               endcase
            end else if (w_tmo) begin
               w_nxt_state = S_ERROR;
            end
         end
         S_LANEID: begin
            if (i_LaneID_Pattern_done) begin
               w_nxt_state = S_WAIT_IDLE;
               w_nxt_msg   = MSG_RES_REQ;
            end
         end
         S_CHECK: begin
            if (int'(r_pass_count) >= PASS_THRESHOLD) begin
               w_nxt_state = S_WAIT_IDLE;
               w_nxt_msg   = MSG_DONE_REQ;
            end else if (int'(r_try_count) < MAX_REVERSALS) begin
               w_nxt_state = S_APPLY;
            end else begin
               w_nxt_state = S_ERROR;
            end
         end
         S_APPLY: begin
            if (i_REVERSAL_done) begin
               w_try_inc   = 1'b1;
               w_nxt_state = S_WAIT_IDLE;
               w_nxt_msg   = MSG_CLR_REQ;
            end
         end
         S_DONE:  w_nxt_state = S_DONE;
         S_ERROR: w_nxt_state = S_ERROR;
         default: w_nxt_state = S_IDLE;
      endcase
      if (!i_start) begin
         w_nxt_state = S_IDLE;
         w_capture   = 1'b0;
         w_try_inc   = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_msg        <= 4'd0;
         r_tmo_cnt    <= '0;
         r_lane_en    <= 2'b00;
         r_apply_en   <= 1'b0;
         r_rev_active <= 1'b0;
         r_tx_msg     <= 4'd0;
         r_tx_vld     <= 1'b0;
         r_end        <= 1'b0;
         r_err        <= 1'b0;
         r_pass_count <= '0;
         r_try_count  <= '0;
      end else begin
         r_state <= w_nxt_state;
         r_msg   <= w_nxt_msg;
         if (w_nxt_state != r_state)
            r_tmo_cnt <= '0;
         else if ((r_state == S_SEND) || (r_state == S_WAIT_RESP))
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
         // outputs follow the next state so they appear with the transition
         r_lane_en  <= (w_nxt_state == S_LANEID) ? 2'b11 : 2'b00;
         r_apply_en <= (w_nxt_state == S_APPLY);
         r_tx_vld   <= (w_nxt_state == S_SEND);
         r_tx_msg   <= (w_nxt_state == S_SEND) ? w_nxt_msg : 4'd0;
         r_end      <= (w_nxt_state == S_DONE);
         r_err      <= (w_nxt_state == S_ERROR);
         if (w_capture) r_pass_count <= popcount(i_Result_logged);
         if (w_try_inc) begin
            r_try_count  <= r_try_count + TRY_W'(1);
            r_rev_active <= ~r_rev_active;
         end
      end
   end

   assign o_LaneID_Pattern_En    = r_lane_en;
   assign o_ApplyReversal_En     = r_apply_en;
   assign o_reversal_active      = r_rev_active;
   assign o_TX_SbMessage         = r_tx_msg;
   assign o_ValidOutDatat_Module = r_tx_vld;
   assign o_Module_end           = r_end;
   assign o_train_error_req      = r_err;
   assign o_pass_count           = r_pass_count;
   assign o_try_count            = r_try_count;

endmodule
